dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 10, SHALL set cycles from request acceptance to ack; legal range 1..63.
REQ-002 Parameter DEPTH_LOG2, default 9, SHALL set storage depth to 2^DEPTH_LOG2 lines of 256 bits.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 enable_i  input  1  SHALL be the request valid from the cache controller.
REQ-006 write_i  input  1  SHALL select write (1) or read (0) for the request.
REQ-007 addr_i  input  32  SHALL be the byte address; bits [4:0] ignored, line index = addr_i[DEPTH_LOG2+4:5].
REQ-008 data_i  input  256  SHALL be the write line data.
REQ-009 ack_o  output  1  SHALL be the one-cycle completion pulse.
REQ-010 data_o  output  256  SHALL be the registered read line data.

Function
REQ-011 States SHALL be IDLE, BUSY, ACK.
REQ-012 IDLE: enable_i=1 at rising edge T0 SHALL capture addr_i, data_i and write_i, load the counter with LATENCY-1, and go to BUSY; enable_i=0 SHALL stay in IDLE.
REQ-013 BUSY: the counter SHALL decrement each edge; at the edge where it reads 0 (edge T0+LATENCY), the state SHALL go to ACK.
REQ-014 That same edge SHALL commit the captured data to the captured index for a write, or load data_o from that index for a read.
REQ-015 ack_o SHALL be 1 only in ACK: exactly one cycle, between edges T0+LATENCY and T0+LATENCY+1.
REQ-016 ACK SHALL go to IDLE unconditionally and SHALL NOT sample enable_i.
REQ-017 The next request is therefore accepted no earlier than edge T0+LATENCY+2.
  - This gives the requester one edge to drop or retarget enable_i after seeing ack.
REQ-018 Inputs SHALL NOT be sampled while in BUSY or ACK.
  - enable_i dropping, or addr_i/data_i changing, mid-operation SHALL NOT alter the captured request.
  - The request SHALL still complete and pulse ack_o.
REQ-019 data_o SHALL hold its value except on a read commit; a write SHALL NOT change data_o.
REQ-020 A read issued after a write completes to the same index SHALL return the written line.
REQ-021 Address bits above DEPTH_LOG2+4 SHALL be ignored, so addresses alias modulo the storage size.
REQ-022 With LATENCY=1, BUSY SHALL last exactly one cycle; the acceptance-to-ack timing of REQ-015 still holds.

Reset
REQ-023 rst_i high SHALL asynchronously force state=IDLE, counter=0, ack_o=0, data_o=0 and clear the captured request registers.
REQ-024 Reset during BUSY or ACK SHALL abort the operation: no write is committed, no ack is issued, and no read data is loaded.
REQ-025 Storage contents SHALL NOT be cleared by reset.
REQ-026 After rst_i falls, the first edge with enable_i=1 SHALL be accepted as in REQ-012.

Structure
REQ-027 A shared package dmem_pkg SHALL hold:
  - the line width (256), address width (32) and offset width (5) constants;
  - the LATENCY default;
  - the state encoding (IDLE/BUSY/ACK).
REQ-028 Storage SHALL be one sub-module, dmem_line_array: single-port, synchronous write, parameterised by DEPTH_LOG2.
REQ-029 The FSM, counter and capture registers SHALL live in dmem_responder.

Verification
REQ-030 Read latency: LATENCY=10, preload index 3 with 256'hA5..A5, enable_i=1, write_i=0, addr_i=32'h60 at edge 0 -> ack_o high only in cycle 10, data_o=256'hA5..A5 from edge 10.
REQ-031 Write then read: write 256'h1234 to addr 32'h400, then read 32'h400 -> second ack returns data_o=256'h1234, and data_o is unchanged during the write ack.
REQ-032 Writeback-then-fill pattern: keep enable_i high through ack, switch write_i 1->0 and change the address -> second request accepted at edge LATENCY+2, two distinct ack pulses, no request lost or duplicated.
REQ-033 Mid-operation input changes: drop enable_i and change addr_i/data_i at edge 3 of a write to 32'h20 -> ack still pulses at edge 10 and index 1 holds the originally captured data.
REQ-034 Reset: assert rst_i at cycle 5 of a write to 32'h80 -> ack_o never pulses, index 4 keeps its old content, data_o=0, and the next request completes normally.
REQ-035 Aliasing and minimum latency: LATENCY=1, DEPTH_LOG2=9, write addr 32'h4000_0020 then read 32'h20 -> same line returned, and each ack comes one cycle after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//
// Holds the line, address and byte-offset widths, the default
// request-to-ack latency, the default storage depth, the width of
// the latency counter and the responder state encoding.

package dmem_pkg;

    localparam int LINE_W             = 256;
    localparam int ADDR_W             = 32;
    localparam int OFFSET_W           = 5;
    localparam int LATENCY_DEFAULT    = 10;
    localparam int DEPTH_LOG2_DEFAULT = 9;

    // Wide enough for LATENCY-1 with LATENCY up to 63.
    localparam int CNT_W              = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array -- single-port line storage for the responder.
//
// Ports:
//   clk_i  in   clock; writes take effect on the rising edge
//   we     in   write enable for the addressed line
//   index  in   line index (DEPTH_LOG2 bits), shared by read and write
//   wdata  in   line to be written
//   rdata  out  combinational view of the addressed line
//
// The owner registers rdata where it needs it, so the array itself has
// no read register.

module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the storage array has no reset branch; its contents must
    // survive reset, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- fixed-latency line memory answering a cache controller.
//
// A request is taken in IDLE, timed out in BUSY for LATENCY cycles, and
// completed with a one-cycle ack in ACK. Writes are committed and read data
// is loaded into data_o on the same edge that enters ACK.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   enable_i  in   request valid, sampled only in IDLE
//   write_i   in   1 = write, 0 = read
//   addr_i    in   byte address; line index = addr_i[DEPTH_LOG2+4:5]
//   data_i    in   write line data
//   ack_o     out  one-cycle completion pulse
//   data_o    out  registered read line data

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    cap_write;
    logic [DEPTH_LOG2-1:0]   cap_index;
    logic [LINE_W-1:0]       cap_data;

    logic                    commit;
    logic                    mem_we;
    logic [LINE_W-1:0]       rd_line;

    // Offset bits and bits above the storage size do not select a line;
    // ignoring the upper ones makes addresses alias modulo the depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_W-1:DEPTH_LOG2+OFFSET_W],
                                addr_i[OFFSET_W-1:0]};

    // The edge on which BUSY sees a zero count is the completion edge.
    assign commit = (state == ST_BUSY) && (cnt == '0);
    assign mem_we = commit && cap_write;

    dmem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_line_array (
        .clk_i (clk_i),
        .we    (mem_we),
        .index (cap_index),
        .wdata (cap_data),
        .rdata (rd_line)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments,
    // so every register sees the pre-edge value of every other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_index <= '0;
            cap_data  <= '0;
            ack_o     <= 1'b0;
            data_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        cap_write <= write_i;
                        cap_index <= addr_i[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
                        cap_data  <= data_i;
                        cnt       <= CNT_LOAD;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_ACK;
                        ack_o <= 1'b1;
                        // Writes leave data_o untouched; the array write
                        // happens through mem_we on this same edge.
                        if (!cap_write) begin
                            data_o <= rd_line;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    // Inputs are deliberately ignored here, giving the
                    // requester one edge to react to ack.
                    ack_o <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed, scoreboarded bench for dmem_responder.
//
// Two instances: u_dut_a with LATENCY=10 and u_dut_b with LATENCY=1, both
// DEPTH_LOG2=9. Each request pushes the expected ack edge and data_o value
// to a per-instance queue; each ack pops and compares.

module tb_dmem_responder;

    typedef struct {
        int           ack_edge;
        logic [255:0] data;
    } exp_t;

    logic         clk;
    logic         rst_a, en_a, wr_a, ack_a;
    logic [31:0]  addr_a;
    logic [255:0] din_a, dout_a;
    logic         rst_b, en_b, wr_b, ack_b;
    logic [31:0]  addr_b;
    logic [255:0] din_b, dout_b;

    int edge_cnt = 0;
    int n_assert = 0;
    int n_fail   = 0;

    exp_t         sb_a[$];
    exp_t         sb_b[$];
    logic [255:0] mem_a[int];
    logic [255:0] mem_b[int];
    logic [255:0] dout_model[2];

    dmem_responder #(.LATENCY(10), .DEPTH_LOG2(9)) u_dut_a (
        .clk_i    (clk),
        .rst_i    (rst_a),
        .enable_i (en_a),
        .write_i  (wr_a),
        .addr_i   (addr_a),
        .data_i   (din_a),
        .ack_o    (ack_a),
        .data_o   (dout_a)
    );

    dmem_responder #(.LATENCY(1), .DEPTH_LOG2(9)) u_dut_b (
        .clk_i    (clk),
        .rst_i    (rst_b),
        .enable_i (en_b),
        .write_i  (wr_b),
        .addr_i   (addr_b),
        .data_i   (din_b),
        .ack_o    (ack_b),
        .data_o   (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(bit sel);
        return sel ? 1 : 10;
    endfunction

    function automatic logic get_ack(bit sel);
        return sel ? ack_b : ack_a;
    endfunction

    function automatic logic [255:0] get_dout(bit sel);
        return sel ? dout_b : dout_a;
    endfunction

    task automatic drive(bit sel, logic en, logic wr, logic [31:0] addr,
                         logic [255:0] din);
        if (sel) begin
            en_b = en; wr_b = wr; addr_b = addr; din_b = din;
        end else begin
            en_a = en; wr_a = wr; addr_a = addr; din_a = din;
        end
    endtask

    task automatic set_en(bit sel, logic en);
        if (sel) en_b = en;
        else     en_a = en;
    endtask

    // Called at a negedge with the request already on the pins: the next
    // rising edge accepts it, so ack is due LATENCY edges after that.
    task automatic push(bit sel, logic wr, logic [31:0] addr, logic [255:0] din);
        exp_t e;
        int   idx;
        idx        = int'(addr[13:5]);
        e.ack_edge = edge_cnt + 1 + lat(sel);
        if (wr) begin
            if (sel) mem_b[idx] = din;
            else     mem_a[idx] = din;
            e.data = dout_model[sel];
        end else begin
            e.data = sel ? mem_b[idx] : mem_a[idx];
            dout_model[sel] = e.data;
        end
        if (sel) sb_b.push_back(e);
        else     sb_a.push_back(e);
    endtask

    task automatic issue(bit sel, logic wr, logic [31:0] addr, logic [255:0] din);
        drive(sel, 1'b1, wr, addr, din);
        push(sel, wr, addr, din);
        @(posedge clk);
        @(negedge clk);
        set_en(sel, 1'b0);
    endtask

    task automatic wait_ack(bit sel, string tag);
        bit   found;
        exp_t e;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (get_ack(sel) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check({tag, "_ack_timeout"}, 256'(found), 256'(1));
        end else if ((sel ? sb_b.size() : sb_a.size()) == 0) begin
            check({tag, "_unexpected_ack"}, 256'(1), 256'(0));
        end else begin
            e = sel ? sb_b.pop_front() : sb_a.pop_front();
            check({tag, "_ack_edge"}, 256'(edge_cnt), 256'(e.ack_edge));
            check({tag, "_data"}, get_dout(sel), e.data);
            @(negedge clk);
            check({tag, "_ack_one_cycle"}, 256'(get_ack(sel)), 256'(0));
        end
    endtask

    task automatic expect_quiet(bit sel, int cycles, string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (get_ack(sel) !== 1'b0) seen++;
        end
        check(tag, 256'(seen), 256'(0));
    endtask

    localparam logic [255:0] D_A5  = {32{8'hA5}};
    localparam logic [255:0] D_WB  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D_33  = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] D_BAD = {8{32'h5555_AAAA}};
    localparam logic [255:0] D_OLD = {16{16'h0BAD}};
    localparam logic [255:0] D_NEW = {16{16'hF00D}};
    localparam logic [255:0] D_35  = {8{32'hC0FF_EE35}};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 256'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 256'h0);
        dout_model[0] = '0;
        dout_model[1] = '0;

        // Reset state
        #1;
        check("reset_ack_a",  256'(ack_a), 256'(0));
        check("reset_dout_a", dout_a, 256'h0);
        check("reset_ack_b",  256'(ack_b), 256'(0));
        check("reset_dout_b", dout_b, 256'h0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Read latency: preload index 3 then read it
        issue(1'b0, 1'b1, 32'h60, D_A5);
        wait_ack(1'b0, "preload_idx3");
        issue(1'b0, 1'b0, 32'h60, 256'h0);
        wait_ack(1'b0, "read_idx3");

        // Write then read; the write ack must leave data_o at A5..A5
        issue(1'b0, 1'b1, 32'h400, 256'h1234);
        wait_ack(1'b0, "write_400");
        issue(1'b0, 1'b0, 32'h400, 256'h0);
        wait_ack(1'b0, "read_400");

        // Writeback-then-fill with enable held high through the ack
        drive(1'b0, 1'b1, 1'b1, 32'h800, D_WB);
        push(1'b0, 1'b1, 32'h800, D_WB);
        wait_ack(1'b0, "wb_write_800");
        drive(1'b0, 1'b1, 1'b0, 32'h60, 256'h0);
        push(1'b0, 1'b0, 32'h60, 256'h0);
        wait_ack(1'b0, "fill_read_60");
        set_en(1'b0, 1'b0);
        expect_quiet(1'b0, 15, "no_duplicate_ack");
        issue(1'b0, 1'b0, 32'h800, 256'h0);
        wait_ack(1'b0, "read_back_800");

        // Inputs changed mid-operation must not alter the captured write
        drive(1'b0, 1'b1, 1'b1, 32'h20, D_33);
        push(1'b0, 1'b1, 32'h20, D_33);
        @(posedge clk);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h40, D_BAD);
        wait_ack(1'b0, "midop_write_20");
        issue(1'b0, 1'b0, 32'h20, 256'h0);
        wait_ack(1'b0, "midop_read_20");

        // Reset in the middle of a write aborts it
        issue(1'b0, 1'b1, 32'h80, D_OLD);
        wait_ack(1'b0, "old_write_80");
        drive(1'b0, 1'b1, 1'b1, 32'h80, D_NEW);
        @(posedge clk);
        repeat (5) @(negedge clk);
        set_en(1'b0, 1'b0);
        rst_a = 1'b1;
        #1;
        check("abort_ack_low",   256'(ack_a), 256'(0));
        check("abort_dout_zero", dout_a, 256'h0);
        dout_model[0] = '0;
        @(negedge clk);
        rst_a = 1'b0;
        expect_quiet(1'b0, 15, "abort_no_ack");
        issue(1'b0, 1'b0, 32'h80, 256'h0);
        wait_ack(1'b0, "after_abort_read_80");

        // Minimum latency and address aliasing on the LATENCY=1 instance
        issue(1'b1, 1'b1, 32'h4000_0020, D_35);
        wait_ack(1'b1, "alias_write");
        issue(1'b1, 1'b0, 32'h20, 256'h0);
        wait_ack(1'b1, "alias_read");

        check("sb_a_drained", 256'(sb_a.size()), 256'(0));
        check("sb_b_drained", 256'(sb_b.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
